sequential_divider: RTL

Iterative unsigned radix-2 restoring divider; the inverse of the 32x32->64 Wallace tree multiplier. It takes a 2*WIDTH-bit dividend (for example a multiplier product) and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and remainder over WIDTH cycles. It uses a start/busy/done handshake and flags divide-by-zero and quotient overflow. It shares the multiplier's datapath neighbourhood and operand widths.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/sequential_divider.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: default width,
// FSM state encoding and iteration-counter width.
package div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_divisor_ext;

    // The incoming remainder is always below the divisor, so its MSB is zero
    // and the shifted value still fits in WIDTH+1 bits.
    assign w_shift       = {i_rem[WIDTH-1:0], i_q_msb};
    assign w_divisor_ext = {1'b0, i_divisor};
    assign o_q_bit       = (w_shift >= w_divisor_ext);
    assign o_rem         = o_q_bit ? (w_shift - w_divisor_ext) : w_shift;

endmodule

// File: rtl/sequential_divider.sv
// Iterative unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with divide-by-zero and overflow short-cuts.
//
// state  | meaning
// IDLE   | waiting for start; results and flags held
// RUN    | one shift/subtract step per edge, WIDTH steps in total
// DONE   | single-cycle done pulse, then back to IDLE
module sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [2*WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder,
    output logic               o_div_by_zero,
    output logic               o_overflow
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH:0]   w_rem_nxt;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_last;
    logic             w_dbz;
    logic             w_ovf;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_q_msb   (r_q[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

    assign w_q_nxt = {r_q[WIDTH-2:0], w_q_bit};
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_dbz   = (i_divisor == '0);
    assign w_ovf   = (i_dividend[2*WIDTH-1:WIDTH] >= i_divisor);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = (w_dbz || w_ovf) ? S_DONE : S_RUN;
            S_RUN:  if (w_last)  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_divisor <= i_divisor;
                        r_cnt     <= '0;
                        r_dbz     <= 1'b0;
                        r_ovf     <= 1'b0;
                        if (w_dbz) begin
                            r_dbz       <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= i_dividend[WIDTH-1:0];
                        end else if (w_ovf) begin
                            r_ovf       <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                        end else begin
                            r_rem <= {1'b0, i_dividend[2*WIDTH-1:WIDTH]};
                            r_q   <= i_dividend[WIDTH-1:0];
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_q_nxt;
                        r_remainder <= w_rem_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state == S_RUN);
    assign o_done        = (r_state == S_DONE);
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;
    assign o_overflow    = r_ovf;

endmodule
